// File: rtl/rgb_led_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rgb_led_arbiter_pkg : state encodings, colours, 27 MHz periods    |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package rgb_led_arbiter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_OWN  = 2'd2;

   localparam logic [23:0] RGB_OFF = 24'h000000;

   localparam int unsigned CLK_HZ        = 27_000_000;
   localparam int unsigned MS_250_CYCLES = CLK_HZ / 4;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Hold counter must represent MIN_HOLD-1; a zero hold still needs one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_led_arbiter_prio_enc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rgb_led_arbiter_prio_enc : find-first-set, index 0 wins           |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module rgb_led_arbiter_prio_enc
   import rgb_led_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = idx_width(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   index,
   output logic               any
);

   always_comb begin
      onehot = '0;
      index  = '0;
      any    = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req[i] && !any) begin
            onehot[i] = 1'b1;
            index     = IDX_W'(i);
            any       = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rgb_led_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rgb_led_arbiter : fixed-priority sharing of one RGB status LED    |
// | with a minimum display time per newly granted colour. Rev 1.0     |
// +------------------------------------------------------------------+
module rgb_led_arbiter
   import rgb_led_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MIN_HOLD   = MS_250_CYCLES,
   parameter logic [23:0] IDLE_RGB   = RGB_OFF,
   parameter logic        IDLE_BLINK = 1'b0
)(
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [24*NUM_REQ-1:0] req_rgb,
   input  logic [NUM_REQ-1:0]    req_blink,
   output logic [23:0]           rgb,
   output logic                  blink_en,
   output logic [NUM_REQ-1:0]    grant,
   output logic                  busy
);

   localparam int unsigned      IDX_W      = idx_width(NUM_REQ);
   localparam int unsigned      CNT_W      = cnt_width(MIN_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST  = (MIN_HOLD > 0) ? CNT_W'(MIN_HOLD - 1) : '0;
   localparam logic [1:0]       ST_GRANTED = (MIN_HOLD > 0) ? ST_HOLD : ST_OWN;

   logic [1:0]         r_state;
   logic [IDX_W-1:0]   r_owner;
   logic [CNT_W-1:0]   r_cnt;

   logic [NUM_REQ-1:0] w_win_oh;
   logic [IDX_W-1:0]   w_win_idx;
   logic               w_any;
   logic               w_higher;
   logic               w_owner_req;
   logic [23:0]        w_colour [NUM_REQ];

   logic               w_take;
   logic               w_release;
   logic               w_follow;
   logic [1:0]         w_state_nxt;
   logic [IDX_W-1:0]   w_owner_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [23:0]        w_rgb_nxt;
   logic               w_blink_nxt;
   logic [NUM_REQ-1:0] w_grant_nxt;

   rgb_led_arbiter_prio_enc #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_prio_enc (
      .req    (req),
      .onehot (w_win_oh),
      .index  (w_win_idx),
      .any    (w_any)
   );

   generate
      for (genvar g = 0; g < NUM_REQ; g++) begin : g_colour
         assign w_colour[g] = req_rgb[24*g +: 24];
      end
   endgenerate

   // The winner is the lowest set index, so it outranks the owner only if its index is smaller.
   assign w_higher    = w_any && (w_win_idx < r_owner);
   assign w_owner_req = req[r_owner];

   always_comb begin
      w_take    = 1'b0;
      w_release = 1'b0;
      w_follow  = 1'b0;
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      w_rgb_nxt   = rgb;
      w_blink_nxt = blink_en;
      w_grant_nxt = grant;

      case (r_state)
         ST_IDLE: begin
            w_take = w_any;
         end
         ST_HOLD: begin
            if (r_cnt == HOLD_LAST) begin
               if (w_owner_req && !w_higher) begin
                  w_state_nxt = ST_OWN;
                  w_follow    = 1'b1;
               end else if (w_any) begin
                  w_take = 1'b1;
               end else begin
                  w_release = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
               w_follow  = w_owner_req;
            end
         end
         ST_OWN: begin
            if (w_higher) begin
               w_take = 1'b1;
            end else if (!w_owner_req) begin
               w_take    = w_any;
               w_release = !w_any;
            end else begin
               w_follow = 1'b1;
            end
         end
         default: begin
            w_release = 1'b1;
         end
      endcase

      if (w_take) begin
         w_state_nxt = ST_GRANTED;
         w_owner_nxt = w_win_idx;
         w_grant_nxt = w_win_oh;
         w_cnt_nxt   = '0;
         w_rgb_nxt   = w_colour[w_win_idx];
         w_blink_nxt = req_blink[w_win_idx];
      end
      if (w_release) begin
         w_state_nxt = ST_IDLE;
         w_grant_nxt = '0;
         w_cnt_nxt   = '0;
         w_rgb_nxt   = IDLE_RGB;
         w_blink_nxt = IDLE_BLINK;
      end
      if (w_follow) begin
         w_rgb_nxt   = w_colour[r_owner];
         w_blink_nxt = req_blink[r_owner];
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state  <= ST_IDLE;
         r_owner  <= '0;
         r_cnt    <= '0;
         rgb      <= IDLE_RGB;
         blink_en <= IDLE_BLINK;
         grant    <= '0;
         busy     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_cnt    <= w_cnt_nxt;
         rgb      <= w_rgb_nxt;
         blink_en <= w_blink_nxt;
         grant    <= w_grant_nxt;
         busy     <= (w_state_nxt != ST_IDLE);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rgb_led_arbiter : directed self-checking bench, MIN_HOLD = 8   |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_rgb_led_arbiter;

   logic        clk;
   logic        n_rst;
   logic [3:0]  req;
   logic [95:0] req_rgb;
   logic [3:0]  req_blink;
   logic [23:0] rgb;
   logic        blink_en;
   logic [3:0]  grant;
   logic        busy;

   int vec_cnt = 0;
   int err_cnt = 0;

   rgb_led_arbiter #(
      .NUM_REQ    (4),
      .MIN_HOLD   (8),
      .IDLE_RGB   (24'h000000),
      .IDLE_BLINK (1'b0)
   ) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .req       (req),
      .req_rgb   (req_rgb),
      .req_blink (req_blink),
      .rgb       (rgb),
      .blink_en  (blink_en),
      .grant     (grant),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_rst = 1'b1; req = '0; req_rgb = '0; req_blink = '0;
      #2 n_rst = 1'b0;
      #1;
      vec_cnt++;
      if ({grant, rgb, blink_en, busy} !== {4'b0000, 24'h000000, 1'b0, 1'b0}) begin
         err_cnt++;
         $display("FAIL reset_async: got grant=%b rgb=%h blink=%b busy=%b, want 0000/000000/0/0", grant, rgb, blink_en, busy);
      end
      tick();
      n_rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         vec_cnt++;
         if ({grant, rgb, blink_en, busy} !== {4'b0000, 24'h000000, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL reset_idle c=%0d: got grant=%b rgb=%h blink=%b busy=%b, want 0000/000000/0/0", c, grant, rgb, blink_en, busy);
         end
      end
   endtask

   task automatic test_pulse();
      req_rgb[2*24 +: 24] = 24'hFF0000;
      req_blink = 4'b0100;
      req = 4'b0100;
      for (int c = 0; c < 8; c++) begin
         tick();
         req = 4'b0000;
         vec_cnt++;
         if ({grant, rgb, blink_en, busy} !== {4'b0100, 24'hFF0000, 1'b1, 1'b1}) begin
            err_cnt++;
            $display("FAIL pulse_hold c=%0d: got grant=%b rgb=%h blink=%b busy=%b, want 0100/ff0000/1/1", c, grant, rgb, blink_en, busy);
         end
      end
      tick();
      vec_cnt++;
      if ({grant, rgb, blink_en, busy} !== {4'b0000, 24'h000000, 1'b0, 1'b0}) begin
         err_cnt++;
         $display("FAIL pulse_expire: got grant=%b rgb=%h blink=%b busy=%b, want 0000/000000/0/0", grant, rgb, blink_en, busy);
      end
      req_blink = 4'b0000;
   endtask

   task automatic test_no_preempt();
      req_rgb[3*24 +: 24] = 24'h00FF00;
      req_rgb[0*24 +: 24] = 24'h0000FF;
      req = 4'b1000;
      for (int c = 0; c < 8; c++) begin
         tick();
         vec_cnt++;
         if ({grant, rgb, busy} !== {4'b1000, 24'h00FF00, 1'b1}) begin
            err_cnt++;
            $display("FAIL nopreempt_hold c=%0d: got grant=%b rgb=%h busy=%b, want 1000/00ff00/1", c, grant, rgb, busy);
         end
         if (c == 3) req = 4'b1001;
      end
      tick();
      vec_cnt++;
      if ({grant, rgb, busy} !== {4'b0001, 24'h0000FF, 1'b1}) begin
         err_cnt++;
         $display("FAIL nopreempt_expire: got grant=%b rgb=%h busy=%b, want 0001/0000ff/1", grant, rgb, busy);
      end
      req = 4'b0000;
      repeat (8) tick();
      vec_cnt++;
      if ({grant, rgb, busy} !== {4'b0000, 24'h000000, 1'b0}) begin
         err_cnt++;
         $display("FAIL nopreempt_drain: got grant=%b rgb=%h busy=%b, want 0000/000000/0", grant, rgb, busy);
      end
   endtask

   task automatic test_own_preempt();
      req_rgb[2*24 +: 24] = 24'hAA00AA;
      req_rgb[1*24 +: 24] = 24'h00AAAA;
      req_rgb[3*24 +: 24] = 24'h333333;
      req = 4'b0100;
      repeat (9) tick();
      req = 4'b1100;
      for (int c = 0; c < 3; c++) begin
         tick();
         vec_cnt++;
         if ({grant, rgb, busy} !== {4'b0100, 24'hAA00AA, 1'b1}) begin
            err_cnt++;
            $display("FAIL own_keep c=%0d: got grant=%b rgb=%h busy=%b, want 0100/aa00aa/1", c, grant, rgb, busy);
         end
      end
      req = 4'b1110;
      for (int c = 0; c < 9; c++) begin
         tick();
         vec_cnt++;
         if ({grant, rgb, busy} !== {4'b0010, 24'h00AAAA, 1'b1}) begin
            err_cnt++;
            $display("FAIL own_preempt c=%0d: got grant=%b rgb=%h busy=%b, want 0010/00aaaa/1", c, grant, rgb, busy);
         end
      end
      req = 4'b1100;
      tick();
      vec_cnt++;
      if ({grant, rgb, busy} !== {4'b0100, 24'hAA00AA, 1'b1}) begin
         err_cnt++;
         $display("FAIL own_rearb: got grant=%b rgb=%h busy=%b, want 0100/aa00aa/1", grant, rgb, busy);
      end
      req = 4'b0000;
      repeat (8) tick();
      vec_cnt++;
      if ({grant, rgb, busy} !== {4'b0000, 24'h000000, 1'b0}) begin
         err_cnt++;
         $display("FAIL own_drain: got grant=%b rgb=%h busy=%b, want 0000/000000/0", grant, rgb, busy);
      end
   endtask

   task automatic test_live_colour();
      req_rgb[0*24 +: 24] = 24'h112233;
      req = 4'b0001;
      tick();
      vec_cnt++;
      if ({grant, rgb} !== {4'b0001, 24'h112233}) begin
         err_cnt++;
         $display("FAIL live_first: got grant=%b rgb=%h, want 0001/112233", grant, rgb);
      end
      req_rgb[0*24 +: 24] = 24'h445566;
      tick();
      vec_cnt++;
      if ({grant, rgb} !== {4'b0001, 24'h445566}) begin
         err_cnt++;
         $display("FAIL live_follow: got grant=%b rgb=%h, want 0001/445566", grant, rgb);
      end
      req = 4'b0000;
      req_rgb[0*24 +: 24] = 24'h778899;
      for (int c = 2; c < 8; c++) begin
         tick();
         vec_cnt++;
         if ({grant, rgb, busy} !== {4'b0001, 24'h445566, 1'b1}) begin
            err_cnt++;
            $display("FAIL live_frozen c=%0d: got grant=%b rgb=%h busy=%b, want 0001/445566/1", c, grant, rgb, busy);
         end
      end
      tick();
      vec_cnt++;
      if ({grant, rgb, busy} !== {4'b0000, 24'h000000, 1'b0}) begin
         err_cnt++;
         $display("FAIL live_expire: got grant=%b rgb=%h busy=%b, want 0000/000000/0", grant, rgb, busy);
      end
   endtask

   task automatic test_reset_mid();
      req_rgb[1*24 +: 24] = 24'h123456;
      req = 4'b0010;
      repeat (5) tick();
      vec_cnt++;
      if ({grant, rgb, busy} !== {4'b0010, 24'h123456, 1'b1}) begin
         err_cnt++;
         $display("FAIL rstmid_before: got grant=%b rgb=%h busy=%b, want 0010/123456/1", grant, rgb, busy);
      end
      #2 n_rst = 1'b0;
      #1;
      vec_cnt++;
      if ({grant, rgb, blink_en, busy} !== {4'b0000, 24'h000000, 1'b0, 1'b0}) begin
         err_cnt++;
         $display("FAIL rstmid_async: got grant=%b rgb=%h blink=%b busy=%b, want 0000/000000/0/0", grant, rgb, blink_en, busy);
      end
      repeat (2) tick();
      vec_cnt++;
      if ({grant, rgb, busy} !== {4'b0000, 24'h000000, 1'b0}) begin
         err_cnt++;
         $display("FAIL rstmid_held: got grant=%b rgb=%h busy=%b, want 0000/000000/0", grant, rgb, busy);
      end
      n_rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         req = 4'b0000;
         vec_cnt++;
         if ({grant, rgb, busy} !== {4'b0010, 24'h123456, 1'b1}) begin
            err_cnt++;
            $display("FAIL rstmid_regrant c=%0d: got grant=%b rgb=%h busy=%b, want 0010/123456/1", c, grant, rgb, busy);
         end
      end
      tick();
      vec_cnt++;
      if ({grant, rgb, busy} !== {4'b0000, 24'h000000, 1'b0}) begin
         err_cnt++;
         $display("FAIL rstmid_expire: got grant=%b rgb=%h busy=%b, want 0000/000000/0", grant, rgb, busy);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_pulse();
      test_no_preempt();
      test_own_preempt();
      test_live_colour();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
`default_nettype wire
